// File: rtl/mbc_handshake_pkg.sv
// Shared types and constants for the console-side MBC boot handshake receiver.
package mbc_handshake_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        WAIT_LOW = 3'd2,
        COMPARE  = 3'd3,
        DONE     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_TIMEOUT  = 2'd1,
        ST_MISMATCH = 2'd2,
        ST_BAD_IDLE = 2'd3
    } status_e;

    localparam int          MBC_PATTERN_LEN    = 19;
    localparam logic [18:0] MBC_PATTERN        = 19'h45140;
    localparam logic [3:0]  UNLOCK_ADDR_HI     = 4'hA;
    localparam logic [3:0]  UNLOCK_ADDR_LO_NIB = 4'h5;

    // Bit 0 is the alignment (low) bit; the rest is the cart authentication sequence.
    function automatic logic exp_bit(input logic [4:0] idx);
        return MBC_PATTERN[idx];
    endfunction

endpackage

// File: rtl/mbc_bit_sync.sv
// Reset-to-one input synchronizer; STAGES=0 passes the input straight through.
module mbc_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_direct
            assign q = d;
        end else begin : g_sync
            logic [STAGES-1:0] sync_d;
            logic [STAGES-1:0] sync_q;

            // Shift chain next-value: new sample enters at stage 0.
            always_comb begin
                sync_d[0] = d;
                for (int i = 1; i < STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // Synchronizer flops; the line idles high, so reset to ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign q = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mbc_handshake_receiver.sv
// Console-side MBC boot handshake: drives the unlock address, aligns on the first low
// MBC bit and checks the 19-bit authentication pattern.
module mbc_handshake_receiver
    import mbc_handshake_pkg::*;
#(
    parameter logic [3:0] ADDR_LO_HI  = 4'hA,
    parameter int         ADDR_CYCLES = 1,
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 64
) (
    input  logic        SClk,
    input  logic        nReset,
    input  logic        Start,
    output logic [7:0]  AddrLo,
    output logic [3:0]  AddrHi,
    output logic        AddrValid,
    input  logic        MBC,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [1:0]  Status,
    output logic [4:0]  ErrIdx,
    output logic [18:0] Captured
);

    logic        mbc_s;
    logic        start_go_s;
    state_e      state_d, state_q;
    status_e     status_d, status_q;
    logic [7:0]  timer_d, timer_q;
    logic [4:0]  cnt_d, cnt_q;
    logic [18:0] captured_d, captured_q;
    logic [4:0]  err_idx_d, err_idx_q;
    logic        mismatch_d, mismatch_q;
    logic [7:0]  addr_lo_d, addr_lo_q;
    logic [3:0]  addr_hi_d, addr_hi_q;
    logic        addr_valid_d, addr_valid_q;
    logic        busy_d, busy_q;
    logic        done_d, done_q;
    logic        pass_d, pass_q;
    logic [4:0]  err_out_d, err_out_q;

    mbc_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (SClk),
        .rst_n (nReset),
        .d     (MBC),
        .q     (mbc_s)
    );

    assign start_go_s = Start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state, timer, bit counter and capture/compare datapath.
    always_comb begin
        if (start_go_s) begin
            timer_d    = 8'd0;
            cnt_d      = 5'd0;
            captured_d = 19'd0;
            err_idx_d  = 5'd0;
            mismatch_d = 1'b0;
            status_d   = ST_OK;
        end else begin
            timer_d    = timer_q;
            cnt_d      = cnt_q;
            captured_d = captured_q;
            err_idx_d  = err_idx_q;
            mismatch_d = mismatch_q;
            status_d   = status_q;
        end
        state_d = state_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_go_s) begin
                    state_d = ADDR;
                end else begin
                    state_d = state_q;
                end
            end
            ADDR: begin
                if (timer_q == 8'(ADDR_CYCLES - 1)) begin
                    state_d = WAIT_LOW;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            WAIT_LOW: begin
                if (!mbc_s) begin
                    if (timer_q == 8'd0) begin
                        // A low line on the very first look means the cart is not idling.
                        state_d  = DONE;
                        status_d = ST_BAD_IDLE;
                    end else begin
                        state_d       = COMPARE;
                        captured_d[0] = 1'b0;
                        cnt_d         = 5'd1;
                    end
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            COMPARE: begin
                captured_d[cnt_q] = mbc_s;
                if ((mbc_s != exp_bit(cnt_q)) && !mismatch_q) begin
                    mismatch_d = 1'b1;
                    err_idx_d  = cnt_q;
                end else begin
                    mismatch_d = mismatch_q;
                end
                if (cnt_q == 5'(MBC_PATTERN_LEN - 1)) begin
                    state_d  = DONE;
                    status_d = mismatch_d ? ST_MISMATCH : ST_OK;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values decoded from the next state so the ports come straight from flops.
    always_comb begin
        addr_valid_d = (state_d == ADDR);
        addr_lo_d    = addr_valid_d ? {ADDR_LO_HI, UNLOCK_ADDR_LO_NIB} : 8'h00;
        addr_hi_d    = addr_valid_d ? UNLOCK_ADDR_HI : 4'h0;
        busy_d       = (state_d == ADDR) || (state_d == WAIT_LOW) || (state_d == COMPARE);
        done_d       = (state_d == DONE);
        pass_d       = done_d && (status_d == ST_OK);
        err_out_d    = (status_d == ST_MISMATCH) ? err_idx_d : 5'd0;
    end

    // State, datapath and output registers.
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            status_q     <= ST_OK;
            timer_q      <= 8'd0;
            cnt_q        <= 5'd0;
            captured_q   <= 19'd0;
            err_idx_q    <= 5'd0;
            mismatch_q   <= 1'b0;
            addr_lo_q    <= 8'h00;
            addr_hi_q    <= 4'h0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_out_q    <= 5'd0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            captured_q   <= captured_d;
            err_idx_q    <= err_idx_d;
            mismatch_q   <= mismatch_d;
            addr_lo_q    <= addr_lo_d;
            addr_hi_q    <= addr_hi_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_out_q    <= err_out_d;
        end
    end

    assign AddrLo    = addr_lo_q;
    assign AddrHi    = addr_hi_q;
    assign AddrValid = addr_valid_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pass      = pass_q;
    assign Status    = status_q;
    assign ErrIdx    = err_out_q;
    assign Captured  = captured_q;

endmodule

// File: tb/tb_mbc_handshake_receiver.sv
// Scoreboard bench for mbc_handshake_receiver with a simple cart-side serial model.
module tb_mbc_handshake_receiver;

    localparam logic [18:0] GOLD = (19'd1 << 6) | (19'd1 << 8) | (19'd1 << 12) |
                                   (19'd1 << 14) | (19'd1 << 18);

    typedef struct packed {
        logic [1:0]  status;
        logic        pass;
        logic [4:0]  err;
        logic [18:0] cap;
        logic [31:0] done_cyc;
    } exp_t;

    logic        SClk = 1'b0;
    logic        nReset = 1'b0;
    logic        Start = 1'b0;
    logic        MBC;
    logic [7:0]  AddrLo;
    logic [3:0]  AddrHi;
    logic        AddrValid;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic [1:0]  Status;
    logic [4:0]  ErrIdx;
    logic [18:0] Captured;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb[$];
    logic        cart_on = 1'b0;
    logic        idle_lvl = 1'b1;
    logic [18:0] cart_pat = 19'd0;
    int          cart_low = 0;

    mbc_handshake_receiver dut (
        .SClk      (SClk),
        .nReset    (nReset),
        .Start     (Start),
        .AddrLo    (AddrLo),
        .AddrHi    (AddrHi),
        .AddrValid (AddrValid),
        .MBC       (MBC),
        .Busy      (Busy),
        .Done      (Done),
        .Pass      (Pass),
        .Status    (Status),
        .ErrIdx    (ErrIdx),
        .Captured  (Captured)
    );

    always #5 SClk = ~SClk;

    always @(posedge SClk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: cart pattern, 1: line stuck high, 2: line low before start. n = cyc at Start drive.
    function automatic exp_t model(input int mode, input logic [18:0] pat, input int n);
        exp_t e;
        bit   found;
        e = '0;
        found = 1'b0;
        case (mode)
            0: begin
                e.cap = pat;
                for (int i = 1; i < 19; i++) begin
                    if (!found && (pat[i] != GOLD[i])) begin
                        found = 1'b1;
                        e.err = 5'(i);
                    end
                end
                e.status   = found ? 2'd2 : 2'd0;
                e.pass     = !found;
                e.done_cyc = 32'(n + 24);
            end
            1: begin
                e.status   = 2'd1;
                e.done_cyc = 32'(n + 66);
            end
            default: begin
                e.status   = 2'd3;
                e.done_cyc = 32'(n + 3);
            end
        endcase
        return e;
    endfunction

    // Cart model: idle level, or the 19 pattern bits starting at cycle cart_low.
    initial begin
        MBC = 1'b1;
        forever begin
            @(negedge SClk);
            if (cart_on && (cyc >= cart_low) && (cyc < cart_low + 19)) begin
                MBC = cart_pat[cyc - cart_low];
            end else begin
                MBC = idle_lvl;
            end
        end
    end

    // Scoreboard consumer: each Done rising edge pops one expected result.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(posedge SClk);
            #1;
            if (Done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("status", 32'(Status), 32'(e.status));
                    chk("pass", 32'(Pass), 32'(e.pass));
                    chk("err_idx", 32'(ErrIdx), 32'(e.err));
                    chk("captured", 32'(Captured), 32'(e.cap));
                    chk("done_cycle", 32'(cyc), e.done_cyc);
                end
            end
            done_prev = Done;
        end
    end

    task automatic wait_done();
        int k;
        k = 0;
        while (!Done && k < 300) begin
            @(posedge SClk);
            #1;
            k++;
        end
        chk("done_seen", 32'(Done), 32'd1);
    endtask

    task automatic do_run(input int mode, input logic [18:0] pat);
        int n;
        @(negedge SClk);
        Start = 1'b1;
        n = cyc;
        if (mode == 0) begin
            cart_pat = pat;
            cart_low = n + 3;
            cart_on  = 1'b1;
        end
        sb.push_back(model(mode, pat, n));
        @(posedge SClk);
        #1;
        chk("addr_valid", 32'(AddrValid), 32'd1);
        chk("addr_lo", 32'(AddrLo), 32'hA5);
        chk("addr_hi", 32'(AddrHi), 32'hA);
        Start = 1'b0;
        @(posedge SClk);
        #1;
        chk("addr_len", 32'(AddrValid), 32'd0);
        wait_done();
        cart_on = 1'b0;
        repeat (3) @(posedge SClk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        int k;
        logic prev;

        repeat (3) @(posedge SClk);
        #1;
        chk("reset_ctrl", 32'({AddrLo, AddrHi, AddrValid, Busy, Done, Pass, Status, ErrIdx}), 32'd0);
        chk("reset_cap", 32'(Captured), 32'd0);
        @(negedge SClk);
        nReset = 1'b1;
        repeat (3) @(posedge SClk);
        #1;
        chk("idle_ctrl", 32'({AddrLo, AddrHi, AddrValid, Busy, Done, Pass, Status, ErrIdx}), 32'd0);

        do_run(0, GOLD);
        do_run(1, 19'd0);
        do_run(0, GOLD & ~(19'd1 << 8));
        do_run(0, GOLD & ~(19'd1 << 8) & ~(19'd1 << 12));

        idle_lvl = 1'b0;
        repeat (5) @(negedge SClk);
        do_run(2, 19'd0);
        idle_lvl = 1'b1;
        repeat (5) @(negedge SClk);

        // Reset while capturing bit 10.
        @(negedge SClk);
        Start = 1'b1;
        n = cyc;
        cart_pat = GOLD;
        cart_low = n + 3;
        cart_on  = 1'b1;
        sb.push_back(model(0, GOLD, n));
        @(negedge SClk);
        Start = 1'b0;
        while (cyc < n + 15) @(posedge SClk);
        #1;
        chk("busy_mid", 32'(Busy), 32'd1);
        nReset = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({AddrLo, AddrHi, AddrValid, Busy, Done, Pass, Status, ErrIdx}), 32'd0);
        chk("rst_mid_cap", 32'(Captured), 32'd0);
        sb.delete();
        cart_on = 1'b0;
        repeat (3) @(negedge SClk);
        nReset = 1'b1;
        repeat (3) @(negedge SClk);
        do_run(0, GOLD);

        // Start pulse during WAIT_LOW must be ignored.
        fork
            do_run(1, 19'd0);
            begin
                repeat (20) @(negedge SClk);
                Start = 1'b1;
                @(negedge SClk);
                Start = 1'b0;
            end
        join

        // Start held high: back-to-back timeout runs, one per DONE visit.
        @(negedge SClk);
        Start = 1'b1;
        n = cyc;
        sb.push_back(model(1, 19'd0, n));
        sb.push_back(model(1, 19'd0, n + 66));
        sb.push_back(model(1, 19'd0, n + 132));
        seen = 0;
        k = 0;
        prev = Done;
        while (seen < 3 && k < 400) begin
            @(posedge SClk);
            #1;
            k++;
            if (Done && !prev) seen++;
            prev = Done;
        end
        Start = 1'b0;
        chk("held_runs", 32'(seen), 32'd3);
        repeat (5) @(posedge SClk);
        #1;
        chk("held_stays_done", 32'({Done, Busy}), 32'b10);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
